// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
// Holds the state encoding, key code constants, ALU op encoding and strobe bundles.
package calc_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_CLR  = 4'hA;
  localparam logic [3:0] KEY_ADD  = 4'hB;
  localparam logic [3:0] KEY_SUB  = 4'hC;
  localparam logic [3:0] KEY_EQ   = 4'hD;
  localparam logic [3:0] KEY_GETM = 4'hE;
  localparam logic [3:0] KEY_SETM = 4'hF;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_t;

  // Operand/ALU control strobes, one cycle wide.
  typedef struct packed {
    logic a_clear;
    logic a_shift;
    logic b_clear;
    logic b_shift;
    logic alu_start;
  } strobe_t;

  // Memory-path strobes, only present when the memory register is built in.
  typedef struct packed {
    logic a_recall;
    logic b_recall;
    logic mem_store;
  } mem_strobe_t;

  // Translate an operator key into the ALU operation it requests.
  function automatic alu_op_t key_to_op(input logic [3:0] code);
    return (code == KEY_SUB) ? ALU_SUB : ALU_ADD;
  endfunction

endpackage

// File: rtl/calc_key_class.sv
// calc_key_class: purely combinational decode of a keypad code into key classes.
module calc_key_class
  import calc_pkg::*;
(
  input  logic [3:0] key_code,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic       is_mem
);

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
  assign is_eq    = (key_code == KEY_EQ);
  assign is_clr   = (key_code == KEY_CLR);
  assign is_mem   = (key_code == KEY_GETM) || (key_code == KEY_SETM);

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: clocked entry-phase controller for the keypad calculator.
// Owns digit counting, the pending operator and the ALU handshake.
// Optional memory register support is built when CALC_MEM_EN is defined.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       a_clear,
  output logic       a_shift,
  output logic       b_clear,
  output logic       b_shift,
  output logic [3:0] digit,
  output logic       a_recall,
  output logic       b_recall,
  output logic       mem_store,
  output logic       alu_start,
  output logic       alu_op,
  input  logic       alu_done,
  input  logic       alu_ovf,
  output logic       err,
  output logic [2:0] state_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  alu_op_t    op, op_n;
  alu_op_t    next_op, next_op_n;
  logic       chain, chain_n;
  logic       err_q, err_n;
  logic [3:0] digit_q, digit_n;
  strobe_t    strb_q, strb_n;
`ifdef CALC_MEM_EN
  mem_strobe_t mem_q, mem_n;
`endif

  logic is_digit, is_op, is_eq, is_clr, is_mem;

  calc_key_class u_key_class (
    .key_code (key_code),
    .is_digit (is_digit),
    .is_op    (is_op),
    .is_eq    (is_eq),
    .is_clr   (is_clr),
    .is_mem   (is_mem)
  );

  // State and registered outputs; synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    if (rst) begin
      state   <= S_A;
      cnt     <= '0;
      op      <= ALU_ADD;
      next_op <= ALU_ADD;
      chain   <= 1'b0;
      err_q   <= 1'b0;
      digit_q <= '0;
      strb_q  <= '0;
`ifdef CALC_MEM_EN
      mem_q   <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op      <= op_n;
      next_op <= next_op_n;
      chain   <= chain_n;
      err_q   <= err_n;
      digit_q <= digit_n;
      strb_q  <= strb_n;
`ifdef CALC_MEM_EN
      mem_q   <= mem_n;
`endif
    end
  end

  // Next-state and next-strobe decode for the accepted key or the ALU completion.
  always_comb begin
    // NOTE: every signal gets a hold/idle default first so no path can infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    op_n      = op;
    next_op_n = next_op;
    chain_n   = chain;
    err_n     = err_q;
    digit_n   = digit_q;
    strb_n    = '0;
`ifdef CALC_MEM_EN
    mem_n     = '0;
`endif

    if (state == S_EXEC) begin
      // Keys are not accepted here; only the ALU completion moves the FSM.
      if (alu_done) begin
        err_n = alu_ovf;
        if (alu_ovf || !chain) begin
          state_n = S_RES;
        end else begin
          op_n    = next_op;
          cnt_n   = '0;
          state_n = S_OP;
        end
      end
    end else if (key_valid) begin
      if (is_clr) begin
        strb_n.a_clear = 1'b1;
        strb_n.b_clear = 1'b1;
        cnt_n          = '0;
        err_n          = 1'b0;
        state_n        = S_A;
      end else if (err_q) begin
        // Error latched: everything but clear is swallowed.
      end else if (is_digit) begin
        case (state)
          S_A: begin
            if (cnt < MAX_CNT) begin
              strb_n.a_shift = 1'b1;
              digit_n        = key_code;
              cnt_n          = cnt + 4'd1;
            end
          end
          S_RES: begin
            strb_n.a_clear = 1'b1;
            strb_n.a_shift = 1'b1;
            digit_n        = key_code;
            cnt_n          = 4'd1;
            state_n        = S_A;
          end
          S_OP: begin
            strb_n.b_clear = 1'b1;
            strb_n.b_shift = 1'b1;
            digit_n        = key_code;
            cnt_n          = 4'd1;
            state_n        = S_B;
          end
          S_B: begin
            if (cnt < MAX_CNT) begin
              strb_n.b_shift = 1'b1;
              digit_n        = key_code;
              cnt_n          = cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end else if (is_op) begin
        case (state)
          S_A, S_RES: begin
            op_n    = key_to_op(key_code);
            cnt_n   = '0;
            state_n = S_OP;
          end
          S_OP: op_n = key_to_op(key_code);
          S_B: begin
            // Chained operation: finish the pending one, remember the new operator.
            strb_n.alu_start = 1'b1;
            next_op_n        = key_to_op(key_code);
            chain_n          = 1'b1;
            state_n          = S_EXEC;
          end
          default: ;
        endcase
      end else if (is_eq) begin
        if (state == S_B) begin
          strb_n.alu_start = 1'b1;
          chain_n          = 1'b0;
          state_n          = S_EXEC;
        end
      end else if (is_mem) begin
`ifdef CALC_MEM_EN
        if (state == S_A || state == S_RES) begin
          if (key_code == KEY_SETM) begin
            mem_n.mem_store = 1'b1;
          end else begin
            mem_n.a_recall = 1'b1;
            cnt_n          = MAX_CNT;
            state_n        = S_RES;
          end
        end else if (key_code == KEY_GETM && (state == S_OP || state == S_B)) begin
          mem_n.b_recall = 1'b1;
          cnt_n          = MAX_CNT;
          state_n        = S_B;
        end
`endif
      end
    end
  end

  assign key_ready = (state != S_EXEC);
  assign a_clear   = strb_q.a_clear;
  assign a_shift   = strb_q.a_shift;
  assign b_clear   = strb_q.b_clear;
  assign b_shift   = strb_q.b_shift;
  assign alu_start = strb_q.alu_start;
  assign digit     = digit_q;
  assign alu_op    = op;
  assign err       = err_q;
  assign state_o   = state;

`ifdef CALC_MEM_EN
  assign a_recall  = mem_q.a_recall;
  assign b_recall  = mem_q.b_recall;
  assign mem_store = mem_q.mem_store;
`else
  assign a_recall  = 1'b0;
  assign b_recall  = 1'b0;
  assign mem_store = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scoreboard bench for calc_sequencer (MAX_DIGITS = 4).
// Memory expectations follow CALC_MEM_EN.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       a_clear, a_shift, b_clear, b_shift;
  logic [3:0] digit;
  logic       a_recall, b_recall, mem_store;
  logic       alu_start, alu_op;
  logic       alu_done, alu_ovf;
  logic       err;
  logic [2:0] state_o;

  // Strobe bit masks: {a_clear,a_shift,b_clear,b_shift,a_recall,b_recall,mem_store,alu_start}
  localparam logic [7:0] A_CLR = 8'h80;
  localparam logic [7:0] A_SH  = 8'h40;
  localparam logic [7:0] B_CLR = 8'h20;
  localparam logic [7:0] B_SH  = 8'h10;
  localparam logic [7:0] A_RC  = 8'h08;
  localparam logic [7:0] B_RC  = 8'h04;
  localparam logic [7:0] M_ST  = 8'h02;
  localparam logic [7:0] ST    = 8'h01;
  localparam logic [7:0] NONE  = 8'h00;

  typedef struct {
    logic [7:0] strb;
    logic [3:0] dig;
    logic       op;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  calc_sequencer #(.MAX_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .a_clear   (a_clear),
    .a_shift   (a_shift),
    .b_clear   (b_clear),
    .b_shift   (b_shift),
    .digit     (digit),
    .a_recall  (a_recall),
    .b_recall  (b_recall),
    .mem_store (mem_store),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_done  (alu_done),
    .alu_ovf   (alu_ovf),
    .err       (err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] obs_strb();
    return {a_clear, a_shift, b_clear, b_shift, a_recall, b_recall, mem_store, alu_start};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present one key at a negedge; its strobes are checked one cycle later.
  task automatic press(input logic [3:0] code, input logic [7:0] strb,
                       input logic [3:0] dig, input logic op, input string tag);
    exp_t e;
    e.strb = strb; e.dig = dig; e.op = op; e.tag = tag;
    exp_q.push_back(e);
    check({tag, "_rdy"}, 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    e = exp_q.pop_front();
    check({e.tag, "_strb"}, 32'(obs_strb()), 32'(e.strb));
    if ((e.strb & (A_SH | B_SH)) != 8'h00) check({e.tag, "_digit"}, 32'(digit), 32'(e.dig));
    if ((e.strb & ST) != 8'h00) check({e.tag, "_op"}, 32'(alu_op), 32'(e.op));
  endtask

  // Called in the first EXEC cycle; raises alu_done after 'delay' cycles.
  task automatic run_alu(input int delay, input logic ovf, input logic exp_op,
                         input int exp_low, input string tag);
    int low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (key_ready !== 1'b0) break;
      low_cnt++;
      check({tag, "_op_hold"}, 32'(alu_op), 32'(exp_op));
      alu_done = (i == delay);
      alu_ovf  = (i == delay) ? ovf : 1'b0;
      @(negedge clk);
    end
    alu_done = 1'b0;
    alu_ovf  = 1'b0;
    check({tag, "_exec_len"}, 32'(low_cnt), 32'(exp_low));
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; alu_done = 1'b0; alu_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_state", 32'(state_o), 32'(S_A));
    check("rst_ready", 32'(key_ready), 32'd1);
    check("rst_strb",  32'(obs_strb()), 32'(NONE));
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_op",    32'(alu_op), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1 2 + 3 = with alu_done three cycles after alu_start
    press(4'h1, A_SH, 4'h1, 1'b0, "t1_k1");
    press(4'h2, A_SH, 4'h2, 1'b0, "t1_k2");
    press(KEY_ADD, NONE, 4'h0, 1'b0, "t1_add");
    check("t1_state_op", 32'(state_o), 32'(S_OP));
    press(4'h3, B_CLR | B_SH, 4'h3, 1'b0, "t1_k3");
    check("t1_state_b", 32'(state_o), 32'(S_B));
    press(KEY_EQ, ST, 4'h0, 1'b0, "t1_eq");
    run_alu(3, 1'b0, 1'b0, 4, "t1");
    check("t1_state_res", 32'(state_o), 32'(S_RES));
    check("t1_err", 32'(err), 32'd0);

    // Digit limit: fifth 9 is swallowed
    press(KEY_CLR, A_CLR | B_CLR, 4'h0, 1'b0, "t2_clr");
    for (int i = 0; i < 4; i++) press(4'h9, A_SH, 4'h9, 1'b0, "t2_k9");
    press(4'h9, NONE, 4'h0, 1'b0, "t2_k9_lim");
    check("t2_state", 32'(state_o), 32'(S_A));

    // Chain 5 - 2 +, then 4 = with overflow
    press(KEY_CLR, A_CLR | B_CLR, 4'h0, 1'b0, "t3_clr");
    press(4'h5, A_SH, 4'h5, 1'b0, "t3_k5");
    press(KEY_SUB, NONE, 4'h0, 1'b0, "t3_sub");
    press(4'h2, B_CLR | B_SH, 4'h2, 1'b0, "t3_k2");
    press(KEY_ADD, ST, 4'h0, 1'b1, "t3_chain");
    run_alu(1, 1'b0, 1'b1, 2, "t3");
    check("t3_state_op", 32'(state_o), 32'(S_OP));
    check("t3_next_op", 32'(alu_op), 32'd0);
    press(4'h4, B_CLR | B_SH, 4'h4, 1'b0, "t3_k4");
    press(KEY_EQ, ST, 4'h0, 1'b0, "t3_eq");
    run_alu(2, 1'b1, 1'b0, 3, "t3_ovf");
    check("t3_err_set", 32'(err), 32'd1);
    check("t3_state_res", 32'(state_o), 32'(S_RES));
    press(4'h7, NONE, 4'h0, 1'b0, "t3_k7_err");
    check("t3_err_hold", 32'(err), 32'd1);
    check("t3_state_hold", 32'(state_o), 32'(S_RES));
    press(KEY_CLR, A_CLR | B_CLR, 4'h0, 1'b0, "t3_clr2");
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_state_a", 32'(state_o), 32'(S_A));

    // Stray alu_done outside EXEC
    alu_done = 1'b1; alu_ovf = 1'b1;
    @(negedge clk);
    alu_done = 1'b0; alu_ovf = 1'b0;
    check("stray_err", 32'(err), 32'd0);
    check("stray_state", 32'(state_o), 32'(S_A));

    // Memory: 4 * A # 3
    press(4'h4, A_SH, 4'h4, 1'b0, "t4_k4");
`ifdef CALC_MEM_EN
    press(KEY_SETM, M_ST, 4'h0, 1'b0, "t4_setm");
    press(KEY_CLR, A_CLR | B_CLR, 4'h0, 1'b0, "t4_clr");
    press(KEY_GETM, A_RC, 4'h0, 1'b0, "t4_getm");
    check("t4_state_res", 32'(state_o), 32'(S_RES));
    press(4'h3, A_CLR | A_SH, 4'h3, 1'b0, "t4_k3");
    press(KEY_ADD, NONE, 4'h0, 1'b0, "t4_add");
    press(KEY_GETM, B_RC, 4'h0, 1'b0, "t4_getm_b");
    check("t4_state_b", 32'(state_o), 32'(S_B));
`else
    press(KEY_SETM, NONE, 4'h0, 1'b0, "t4_setm");
    press(KEY_CLR, A_CLR | B_CLR, 4'h0, 1'b0, "t4_clr");
    press(KEY_GETM, NONE, 4'h0, 1'b0, "t4_getm");
    check("t4_state_a", 32'(state_o), 32'(S_A));
    press(4'h3, A_SH, 4'h3, 1'b0, "t4_k3");
`endif

    // Reset in the middle of EXEC
    press(KEY_CLR, A_CLR | B_CLR, 4'h0, 1'b0, "t5_clr");
    press(4'h1, A_SH, 4'h1, 1'b0, "t5_k1");
    press(KEY_SUB, NONE, 4'h0, 1'b0, "t5_sub");
    press(4'h2, B_CLR | B_SH, 4'h2, 1'b0, "t5_k2");
    press(KEY_EQ, ST, 4'h0, 1'b1, "t5_eq");
    check("t5_in_exec", 32'(key_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_state", 32'(state_o), 32'(S_A));
    check("t5_rst_ready", 32'(key_ready), 32'd1);
    check("t5_rst_strb",  32'(obs_strb()), 32'(NONE));
    check("t5_rst_digit", 32'(digit), 32'd0);
    check("t5_rst_op",    32'(alu_op), 32'd0);
    check("t5_rst_err",   32'(err), 32'd0);
    rst = 1'b0;
    alu_done = 1'b1; alu_ovf = 1'b1;
    @(negedge clk);
    alu_done = 1'b0; alu_ovf = 1'b0;
    check("t5_late_state", 32'(state_o), 32'(S_A));
    check("t5_late_err",   32'(err), 32'd0);
    check("t5_late_strb",  32'(obs_strb()), 32'(NONE));
    press(4'h6, A_SH, 4'h6, 1'b0, "t5_k6");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
